// File: rtl/vc_arbiter_demux.sv
// Drains the VC0/VC1 FIFOs with VC0 priority and a VC1 anti-starvation rule, and routes
// each popped word to destination D0 or D1 by one header bit, two clocks after the pop.
module vc_arbiter_demux #(
  parameter int unsigned data_width    = 6,
  parameter int unsigned dest_bit      = 4,
  parameter int unsigned max_vc0_burst = 4,
  parameter int unsigned cnt_width     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic                  empty_fifo_VC0,
  input  logic                  empty_fifo_VC1,
  input  logic [data_width-1:0] data_out_VC0,
  input  logic [data_width-1:0] data_out_VC1,
  input  logic                  almost_full_D0,
  input  logic                  almost_full_D1,
  input  logic                  full_D0,
  input  logic                  full_D1,
  output logic                  rd_enable_VC0,
  output logic                  rd_enable_VC1,
  output logic                  wr_enable_D0,
  output logic                  wr_enable_D1,
  output logic [data_width-1:0] data_in_D0,
  output logic [data_width-1:0] data_in_D1,
  output logic                  active_out,
  output logic                  idle_out,
  output logic [cnt_width-1:0]  pop_cnt_VC0,
  output logic [cnt_width-1:0]  pop_cnt_VC1
);

  localparam int unsigned burst_width = $clog2(max_vc0_burst + 1);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [burst_width-1:0] burst_q, burst_d;
  logic                   s1_valid_q, s1_valid_d;
  logic                   s1_src_q, s1_src_d;
  logic                   wr_d0_q, wr_d0_d;
  logic                   wr_d1_q, wr_d1_d;
  logic [data_width-1:0]  data_d0_q, data_d0_d;
  logic [data_width-1:0]  data_d1_q, data_d1_d;
  logic [cnt_width-1:0]   cnt_vc0_q, cnt_vc0_d;
  logic [cnt_width-1:0]   cnt_vc1_q, cnt_vc1_d;
  logic                   active_q, active_d;
  logic                   idle_q, idle_d;

  logic                   stall;
  logic                   pop_ok;
  logic                   burst_full;
  logic                   s2_valid;
  logic                   rd_vc0;
  logic                   rd_vc1;
  logic [data_width-1:0]  s1_word;

  assign stall      = almost_full_D0 | almost_full_D1 | full_D0 | full_D1;
  assign pop_ok     = init && (state_q == ST_ACTIVE) && !stall;
  assign burst_full = (burst_q == burst_width'(max_vc0_burst));
  assign s2_valid   = wr_d0_q | wr_d1_q;

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; soft init overrides every transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:   state_d = ST_IDLE;
      ST_IDLE:   if (!empty_fifo_VC0 || !empty_fifo_VC1) state_d = ST_ACTIVE;
      ST_ACTIVE: if (empty_fifo_VC0 && empty_fifo_VC1 && !s1_valid_q && !s2_valid) state_d = ST_IDLE;
      default:   state_d = ST_INIT;
    endcase
    if (!init) state_d = ST_INIT;
  end

  // FSM outputs: pop arbitration, VC0 first unless its burst allowance is used up
  always_comb begin
    rd_vc0 = 1'b0;
    rd_vc1 = 1'b0;
    if (pop_ok) begin
      if (!empty_fifo_VC0 && !(burst_full && !empty_fifo_VC1)) begin
        rd_vc0 = 1'b1;
      end else if (!empty_fifo_VC1) begin
        rd_vc1 = 1'b1;
      end
    end
  end

  assign rd_enable_VC0 = rd_vc0;
  assign rd_enable_VC1 = rd_vc1;

  // Datapath next values: burst tracking, routing of the word returned by the FIFO, counters
  always_comb begin
    s1_word    = s1_src_q ? data_out_VC1 : data_out_VC0;
    s1_valid_d = rd_vc0 | rd_vc1;
    s1_src_d   = rd_vc1;
    wr_d0_d    = s1_valid_q && !s1_word[dest_bit];
    wr_d1_d    = s1_valid_q && s1_word[dest_bit];
    data_d0_d  = wr_d0_d ? s1_word : '0;
    data_d1_d  = wr_d1_d ? s1_word : '0;
    cnt_vc0_d  = cnt_vc0_q + cnt_width'(rd_vc0);
    cnt_vc1_d  = cnt_vc1_q + cnt_width'(rd_vc1);
    burst_d    = burst_q;
    if (rd_vc1 || empty_fifo_VC1) begin
      burst_d = '0;
    end else if (rd_vc0 && !burst_full) begin
      burst_d = burst_q + burst_width'(1);
    end
    active_d = (state_d == ST_ACTIVE);
    idle_d   = (state_d == ST_IDLE) && !s1_valid_d && !(wr_d0_d || wr_d1_d);
    if (!init) begin
      s1_valid_d = 1'b0;
      s1_src_d   = 1'b0;
      wr_d0_d    = 1'b0;
      wr_d1_d    = 1'b0;
      data_d0_d  = '0;
      data_d1_d  = '0;
      cnt_vc0_d  = '0;
      cnt_vc1_d  = '0;
      burst_d    = '0;
      active_d   = 1'b0;
      idle_d     = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      burst_q    <= '0;
      s1_valid_q <= 1'b0;
      s1_src_q   <= 1'b0;
      wr_d0_q    <= 1'b0;
      wr_d1_q    <= 1'b0;
      data_d0_q  <= '0;
      data_d1_q  <= '0;
      cnt_vc0_q  <= '0;
      cnt_vc1_q  <= '0;
      active_q   <= 1'b0;
      idle_q     <= 1'b0;
    end else begin
      burst_q    <= burst_d;
      s1_valid_q <= s1_valid_d;
      s1_src_q   <= s1_src_d;
      wr_d0_q    <= wr_d0_d;
      wr_d1_q    <= wr_d1_d;
      data_d0_q  <= data_d0_d;
      data_d1_q  <= data_d1_d;
      cnt_vc0_q  <= cnt_vc0_d;
      cnt_vc1_q  <= cnt_vc1_d;
      active_q   <= active_d;
      idle_q     <= idle_d;
    end
  end

  assign wr_enable_D0 = wr_d0_q;
  assign wr_enable_D1 = wr_d1_q;
  assign data_in_D0   = data_d0_q;
  assign data_in_D1   = data_d1_q;
  assign active_out   = active_q;
  assign idle_out     = idle_q;
  assign pop_cnt_VC0  = cnt_vc0_q;
  assign pop_cnt_VC1  = cnt_vc1_q;

endmodule

// File: tb/tb_vc_arbiter_demux.sv
// Bench for vc_arbiter_demux: emulates the VC FIFOs, keeps a queue-based model of the
// drain stage and compares every DUT output against it each cycle.
module tb_vc_arbiter_demux;

  localparam int unsigned DW = 6;
  localparam int unsigned CW = 8;
  localparam int M_INIT   = 0;
  localparam int M_IDLE   = 1;
  localparam int M_ACTIVE = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          init;
  logic          empty_fifo_VC0, empty_fifo_VC1;
  logic [DW-1:0] data_out_VC0, data_out_VC1;
  logic          almost_full_D0, almost_full_D1, full_D0, full_D1;
  logic          rd_enable_VC0, rd_enable_VC1;
  logic          wr_enable_D0, wr_enable_D1;
  logic [DW-1:0] data_in_D0, data_in_D1;
  logic          active_out, idle_out;
  logic [CW-1:0] pop_cnt_VC0, pop_cnt_VC1;

  vc_arbiter_demux #(
    .data_width(DW), .dest_bit(4), .max_vc0_burst(4), .cnt_width(CW)
  ) dut (
    .clk(clk), .reset(reset), .init(init),
    .empty_fifo_VC0(empty_fifo_VC0), .empty_fifo_VC1(empty_fifo_VC1),
    .data_out_VC0(data_out_VC0), .data_out_VC1(data_out_VC1),
    .almost_full_D0(almost_full_D0), .almost_full_D1(almost_full_D1),
    .full_D0(full_D0), .full_D1(full_D1),
    .rd_enable_VC0(rd_enable_VC0), .rd_enable_VC1(rd_enable_VC1),
    .wr_enable_D0(wr_enable_D0), .wr_enable_D1(wr_enable_D1),
    .data_in_D0(data_in_D0), .data_in_D1(data_in_D1),
    .active_out(active_out), .idle_out(idle_out),
    .pop_cnt_VC0(pop_cnt_VC0), .pop_cnt_VC1(pop_cnt_VC1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] word;
    int            due;
  } pend_t;

  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  pend_t         pipe[$];
  int            m_state = M_INIT;
  int            m_burst = 0;
  int            m_cnt0 = 0;
  int            m_cnt1 = 0;
  int            grants[$];
  int            dsts[$];
  int            wr_seen = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  // One clock: compare against the model, then advance FIFOs and model across the edge
  task automatic tick();
    int            e_rd0, e_rd1, e_wr0, e_wr1, e_d0, e_d1, a_rd0, a_rd1;
    bit            me0, me1, stall, inflight;
    logic [DW-1:0] w;
    me0 = (q0.size() == 0);
    me1 = (q1.size() == 0);
    empty_fifo_VC0 = me0;
    empty_fifo_VC1 = me1;
    #1;
    stall = almost_full_D0 | almost_full_D1 | full_D0 | full_D1;
    e_rd0 = 0; e_rd1 = 0; w = '0;
    if (m_state == M_ACTIVE && init && !stall) begin
      if (!me0 && !(m_burst == 4 && !me1)) begin
        e_rd0 = 1; w = q0[0];
      end else if (!me1) begin
        e_rd1 = 1; w = q1[0];
      end
    end
    e_wr0 = 0; e_wr1 = 0; e_d0 = 0; e_d1 = 0;
    foreach (pipe[i]) begin
      if (pipe[i].due == cyc) begin
        if (pipe[i].word[4]) begin e_wr1 = 1; e_d1 = int'(pipe[i].word); end
        else begin e_wr0 = 1; e_d0 = int'(pipe[i].word); end
      end
    end
    chk("rd_enable_VC0", int'(rd_enable_VC0), e_rd0);
    chk("rd_enable_VC1", int'(rd_enable_VC1), e_rd1);
    chk("wr_enable_D0", int'(wr_enable_D0), e_wr0);
    chk("wr_enable_D1", int'(wr_enable_D1), e_wr1);
    chk("data_in_D0", int'(data_in_D0), e_d0);
    chk("data_in_D1", int'(data_in_D1), e_d1);
    chk("active_out", int'(active_out), int'(m_state == M_ACTIVE));
    chk("idle_out", int'(idle_out), int'(m_state == M_IDLE && pipe.size() == 0));
    chk("pop_cnt_VC0", int'(pop_cnt_VC0), m_cnt0);
    chk("pop_cnt_VC1", int'(pop_cnt_VC1), m_cnt1);
    a_rd0 = int'(rd_enable_VC0);
    a_rd1 = int'(rd_enable_VC1);
    if (a_rd0 != 0) grants.push_back(0);
    if (a_rd1 != 0) grants.push_back(1);
    if (wr_enable_D0) begin wr_seen++; dsts.push_back(0); end
    if (wr_enable_D1) begin wr_seen++; dsts.push_back(1); end
    @(posedge clk);
    #1;
    if (a_rd0 != 0 && q0.size() > 0) data_out_VC0 = q0.pop_front();
    if (a_rd1 != 0 && q1.size() > 0) data_out_VC1 = q1.pop_front();
    if (!init) begin
      m_state = M_INIT; m_burst = 0; m_cnt0 = 0; m_cnt1 = 0;
      pipe.delete();
    end else begin
      inflight = (pipe.size() > 0);
      if (m_state == M_INIT) m_state = M_IDLE;
      else if (m_state == M_IDLE && (!me0 || !me1)) m_state = M_ACTIVE;
      else if (m_state == M_ACTIVE && me0 && me1 && !inflight) m_state = M_IDLE;
      if (e_rd0 != 0 || e_rd1 != 0) pipe.push_back('{w, cyc + 2});
      m_cnt0 = (m_cnt0 + e_rd0) % 256;
      m_cnt1 = (m_cnt1 + e_rd1) % 256;
      if (e_rd1 != 0 || me1) m_burst = 0;
      else if (e_rd0 != 0 && m_burst < 4) m_burst++;
    end
    while (pipe.size() > 0 && pipe[0].due <= cyc) void'(pipe.pop_front());
    cyc++;
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_grants(input string name, input int n, input int budget);
    for (int i = 0; i < budget && grants.size() < n; i++) tick();
    chk(name, int'(grants.size() >= n), 1);
  endtask

  // Asynchronous reset mid-cycle: every output must clear at once
  task automatic async_reset();
    #2;
    reset = 1'b0;
    #1;
    chk("rst_rd_VC0", int'(rd_enable_VC0), 0);
    chk("rst_rd_VC1", int'(rd_enable_VC1), 0);
    chk("rst_wr_D0", int'(wr_enable_D0), 0);
    chk("rst_wr_D1", int'(wr_enable_D1), 0);
    chk("rst_data_D0", int'(data_in_D0), 0);
    chk("rst_data_D1", int'(data_in_D1), 0);
    chk("rst_active", int'(active_out), 0);
    chk("rst_idle", int'(idle_out), 0);
    chk("rst_cnt_VC0", int'(pop_cnt_VC0), 0);
    chk("rst_cnt_VC1", int'(pop_cnt_VC1), 0);
    m_state = M_INIT; m_burst = 0; m_cnt0 = 0; m_cnt1 = 0;
    pipe.delete(); q0.delete(); q1.delete();
    @(negedge clk);
    reset = 1'b1;
    tick();
    tick();
    #1;
    chk("idle_after_reset", int'(idle_out), 1);
  endtask

  initial begin
    int exp_g[10];
    int exp_d[3];
    exp_g = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    exp_d = '{0, 1, 0};
    reset = 1'b1; init = 1'b1;
    empty_fifo_VC0 = 1'b1; empty_fifo_VC1 = 1'b1;
    data_out_VC0 = '0; data_out_VC1 = '0;
    almost_full_D0 = 1'b0; almost_full_D1 = 1'b0; full_D0 = 1'b0; full_D1 = 1'b0;
    @(negedge clk);
    async_reset();

    // VC0 only: three words routed D0, D1, D0
    q0.push_back(6'h05); q0.push_back(6'h12); q0.push_back(6'h03);
    grants.delete(); dsts.delete();
    ticks(10);
    chk("vc0_pops", grants.size(), 3);
    chk("vc0_pop_cnt", int'(pop_cnt_VC0), 3);
    if (dsts.size() == 3) begin
      for (int i = 0; i < 3; i++) chk($sformatf("vc0_dest%0d", i), dsts[i], exp_d[i]);
    end else begin
      chk("vc0_dest_count", dsts.size(), 3);
    end

    // Both VCs loaded: VC1 forced in after four VC0 pops
    for (int i = 0; i < 10; i++) begin
      q0.push_back(DW'(i * 3));
      q1.push_back(DW'(i * 5 + 1));
    end
    grants.delete();
    ticks(30);
    if (grants.size() >= 10) begin
      for (int i = 0; i < 10; i++) chk($sformatf("grant%0d", i), grants[i], exp_g[i]);
    end else begin
      chk("grant_count", grants.size(), 10);
    end
    chk("both_total_grants", grants.size(), 20);

    // almost_full_D1 during streaming: only the two in-flight words complete
    for (int i = 0; i < 8; i++) q0.push_back(DW'(i * 7 + 2));
    grants.delete();
    wait_grants("stall_wait", 3, 20);
    almost_full_D1 = 1'b1;
    wr_seen = 0;
    ticks(4);
    chk("stall_inflight_writes", wr_seen, 2);
    chk("stall_no_pops", grants.size(), 3);
    almost_full_D1 = 1'b0;
    tick();
    chk("stall_resume", grants.size(), 4);
    ticks(15);

    // Soft init with two words in flight: they are dropped
    for (int i = 0; i < 6; i++) q0.push_back(DW'(i * 9 + 4));
    grants.delete();
    wait_grants("init_wait", 2, 20);
    init = 1'b0;
    tick();
    init = 1'b1;
    wr_seen = 0;
    #1;
    chk("init_cnt_VC0", int'(pop_cnt_VC0), 0);
    chk("init_active", int'(active_out), 0);
    tick();
    #1;
    chk("init_idle", int'(idle_out), 1);
    tick();
    chk("init_no_writes", wr_seen, 0);
    ticks(15);

    // Reset in the middle of a burst
    for (int i = 0; i < 6; i++) q0.push_back(DW'(i + 16));
    for (int i = 0; i < 3; i++) q1.push_back(DW'(i + 40));
    grants.delete();
    wait_grants("reset_wait", 2, 20);
    async_reset();

    // 257 VC1 pops wrap the 8-bit counter to 1
    init = 1'b0;
    tick();
    init = 1'b1;
    tick();
    for (int i = 0; i < 257; i++) q1.push_back(DW'(i));
    ticks(270);
    chk("wrap_drained", q1.size(), 0);
    chk("wrap_cnt_VC1", int'(pop_cnt_VC1), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
